axi_filter_rd_perm: RTL and testbench

Parametrised read-channel AXI address filter with per-range read permission, full-burst range checking and in-order error-response generation. It sits between an AXI read master and its slave in the same position as the existing filter's read path. Bursts that fall fully inside an enabled, readable range are forwarded. Any other burst is absorbed and answered locally with len+1 error beats, ordered behind all forwarded traffic. A sticky violation counter and an interrupt pulse report each blocked burst.

---
 rtl/axi_filter_rd_perm.sv | 214 +++++++++++++++++++++
 tb/tb_axi_filter_rd_perm.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_filter_rd_perm.sv
// Purpose: AXI read-channel filter; forwards bursts fully inside an enabled readable range, answers others with error beats.
// Latency: AR is registered (1 cycle, 1 AR per 2 cycles); R pass-through is combinational (0 cycles).
// Backpressure: AR stalls while the slice is full or in-flight limit is reached; error beats hold under R backpressure.
module axi_filter_rd_perm #(
  parameter int          AXI_ADDR_WIDTH      = 32,
  parameter int          AXI_DATA_WIDTH      = 64,
  parameter int          AXI_ID_WIDTH        = 7,
  parameter int          AXI_USER_WIDTH      = 4,
  parameter int          NBR_RANGE           = 4,
  parameter int          NBR_OUTSTANDING_REQ = 4,
  parameter logic [1:0]  ERR_RESP            = 2'b11,
  parameter int          ERR_CNT_WIDTH       = 16
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0]  START_ADDR,
  input  logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0]  STOP_ADDR,
  input  logic [NBR_RANGE-1:0]                      i_range_rd_en,
  // slave-side AR
  input  logic                                      axi_in_ar_valid,
  output logic                                      axi_in_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]                 axi_in_ar_addr,
  input  logic [2:0]                                axi_in_ar_prot,
  input  logic [3:0]                                axi_in_ar_region,
  input  logic [7:0]                                axi_in_ar_len,
  input  logic [2:0]                                axi_in_ar_size,
  input  logic [1:0]                                axi_in_ar_burst,
  input  logic                                      axi_in_ar_lock,
  input  logic [3:0]                                axi_in_ar_cache,
  input  logic [3:0]                                axi_in_ar_qos,
  input  logic [AXI_ID_WIDTH-1:0]                   axi_in_ar_id,
  input  logic [AXI_USER_WIDTH-1:0]                 axi_in_ar_user,
  // slave-side R
  output logic                                      axi_in_r_valid,
  input  logic                                      axi_in_r_ready,
  output logic [AXI_DATA_WIDTH-1:0]                 axi_in_r_data,
  output logic [1:0]                                axi_in_r_resp,
  output logic                                      axi_in_r_last,
  output logic [AXI_ID_WIDTH-1:0]                   axi_in_r_id,
  output logic [AXI_USER_WIDTH-1:0]                 axi_in_r_user,
  // master-side AR
  output logic                                      axi_out_ar_valid,
  input  logic                                      axi_out_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0]                 axi_out_ar_addr,
  output logic [2:0]                                axi_out_ar_prot,
  output logic [3:0]                                axi_out_ar_region,
  output logic [7:0]                                axi_out_ar_len,
  output logic [2:0]                                axi_out_ar_size,
  output logic [1:0]                                axi_out_ar_burst,
  output logic                                      axi_out_ar_lock,
  output logic [3:0]                                axi_out_ar_cache,
  output logic [3:0]                                axi_out_ar_qos,
  output logic [AXI_ID_WIDTH-1:0]                   axi_out_ar_id,
  output logic [AXI_USER_WIDTH-1:0]                 axi_out_ar_user,
  // master-side R
  input  logic                                      axi_out_r_valid,
  output logic                                      axi_out_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0]                 axi_out_r_data,
  input  logic [1:0]                                axi_out_r_resp,
  input  logic                                      axi_out_r_last,
  input  logic [AXI_ID_WIDTH-1:0]                   axi_out_r_id,
  input  logic [AXI_USER_WIDTH-1:0]                 axi_out_r_user,
  // violation reporting
  output logic [ERR_CNT_WIDTH-1:0]                  o_err_cnt,
  output logic [AXI_ADDR_WIDTH-1:0]                 o_err_addr,
  output logic                                      o_err_irq,
  input  logic                                      i_err_clr
);

  localparam int CW  = $clog2(NBR_OUTSTANDING_REQ + 1);
  localparam int AW1 = AXI_ADDR_WIDTH + 1;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [2:0]                prot;
    logic [3:0]                region;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [3:0]                cache;
    logic [3:0]                qos;
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_USER_WIDTH-1:0] user;
  } ar_t;

  typedef enum logic [1:0] {PASS, DRAIN, ERR} state_t;

  state_t          state_q, state_d;
  ar_t             in_ar, slice;
  logic            slice_vld, slice_allow;
  logic [CW-1:0]   cnt;
  logic [7:0]      beat_cnt;
  logic [AW1-1:0]  beats_x, bytes_x, lo_x, hi_x;
  logic            allow_in;
  logic            out_ar_vld, err_beat, err_done, pass_en;
  logic            in_ar_hs, out_ar_hs, r_last_hs;

  assign in_ar = {axi_in_ar_addr, axi_in_ar_prot, axi_in_ar_region, axi_in_ar_len,
                  axi_in_ar_size, axi_in_ar_burst, axi_in_ar_lock, axi_in_ar_cache,
                  axi_in_ar_qos, axi_in_ar_id, axi_in_ar_user};

  // Burst window of the incoming AR and its match against the enabled readable ranges.
  // WRAP lengths are powers of two by protocol, so the alignment is a simple mask.
  always_comb begin
    beats_x  = AW1'({1'b0, axi_in_ar_len}) + AW1'(1);
    bytes_x  = beats_x << axi_in_ar_size;
    lo_x     = {1'b0, axi_in_ar_addr};
    allow_in = 1'b0;
    if (axi_in_ar_burst == 2'b00) bytes_x = AW1'(1) << axi_in_ar_size;
    if (axi_in_ar_burst == 2'b10) lo_x = lo_x & ~(bytes_x - AW1'(1));
    hi_x = lo_x + bytes_x - AW1'(1);
    if (axi_in_ar_burst != 2'b11 && !hi_x[AXI_ADDR_WIDTH]) begin
      for (int r = 0; r < NBR_RANGE; r++) begin
        if (i_range_rd_en[r] && lo_x[AXI_ADDR_WIDTH-1:0] >= START_ADDR[r]
            && hi_x[AXI_ADDR_WIDTH-1:0] <= STOP_ADDR[r])
          allow_in = 1'b1;
      end
    end
  end

  assign axi_in_ar_ready  = !i_rst && !slice_vld && (state_q == PASS);
  assign in_ar_hs         = axi_in_ar_valid && axi_in_ar_ready;
  assign axi_out_ar_valid = out_ar_vld && !i_rst;
  assign out_ar_hs        = axi_out_ar_valid && axi_out_ar_ready;
  assign r_last_hs        = axi_out_r_valid && axi_out_r_ready && axi_out_r_last;
  assign {axi_out_ar_addr, axi_out_ar_prot, axi_out_ar_region, axi_out_ar_len,
          axi_out_ar_size, axi_out_ar_burst, axi_out_ar_lock, axi_out_ar_cache,
          axi_out_ar_qos, axi_out_ar_id, axi_out_ar_user} = slice;

  // Next-state: a blocked AR waits for forwarded traffic to drain, then emits its error beats.
  always_comb begin
    state_d    = state_q;
    out_ar_vld = 1'b0;
    err_beat   = 1'b0;
    err_done   = 1'b0;
    case (state_q)
      PASS: begin
        out_ar_vld = slice_vld && slice_allow && (cnt < CW'(NBR_OUTSTANDING_REQ));
        if (in_ar_hs && !allow_in) state_d = DRAIN;
      end
      DRAIN: if (cnt == '0) state_d = ERR;
      ERR: begin
        err_beat = !i_rst;
        if (err_beat && axi_in_r_ready && beat_cnt == 8'd0) begin
          err_done = 1'b1;
          state_d  = PASS;
        end
      end
      default: state_d = PASS;
    endcase
  end

  // R mux: slave traffic passes straight through except while error beats are generated.
  always_comb begin
    pass_en         = !i_rst && (state_q != ERR);
    axi_out_r_ready = pass_en && axi_in_r_ready;
    axi_in_r_valid  = pass_en && axi_out_r_valid;
    axi_in_r_data   = pass_en ? axi_out_r_data : '0;
    axi_in_r_resp   = pass_en ? axi_out_r_resp : 2'b00;
    axi_in_r_last   = pass_en && axi_out_r_last;
    axi_in_r_id     = pass_en ? axi_out_r_id   : '0;
    axi_in_r_user   = pass_en ? axi_out_r_user : '0;
    if (err_beat) begin
      axi_in_r_valid = 1'b1;
      axi_in_r_resp  = ERR_RESP;
      axi_in_r_last  = (beat_cnt == 8'd0);
      axi_in_r_id    = slice.id;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= PASS;
    else       state_q <= state_d;
  end

  // AR slice, in-flight counter, error beat counter and violation reporting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slice_vld   <= 1'b0;
      slice_allow <= 1'b0;
      slice       <= '0;
      cnt         <= '0;
      beat_cnt    <= '0;
      o_err_cnt   <= '0;
      o_err_addr  <= '0;
      o_err_irq   <= 1'b0;
    end else begin
      if (in_ar_hs) begin
        slice_vld   <= 1'b1;
        slice       <= in_ar;
        slice_allow <= allow_in;
      end else if (out_ar_hs || err_done) begin
        slice_vld   <= 1'b0;
      end
      if (out_ar_hs && !r_last_hs)      cnt <= cnt + CW'(1);
      else if (!out_ar_hs && r_last_hs) cnt <= cnt - CW'(1);
      if (state_q == DRAIN && state_d == ERR)
        beat_cnt <= slice.len;
      else if (err_beat && axi_in_r_ready && beat_cnt != 8'd0)
        beat_cnt <= beat_cnt - 8'd1;
      o_err_irq <= err_done;
      if (i_err_clr) begin
        o_err_cnt  <= '0;
        o_err_addr <= '0;
      end else if (err_done) begin
        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + ERR_CNT_WIDTH'(1);
        o_err_addr <= slice.addr;
      end
    end
  end

endmodule

// File: tb/tb_axi_filter_rd_perm.sv
// Purpose: directed bench for axi_filter_rd_perm: range-check vector table plus ordering, stall, clear and reset sequences.
// Latency: expects AR forward at N+1, error beats at N+2 when idle, zero-latency R pass-through.
// Backpressure: slave AR ready held high; R ready toggled to exercise held error beats.
module tb_axi_filter_rd_perm;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0][31:0]  start_addr, stop_addr;
  logic [3:0]        range_en;
  logic              in_ar_valid, in_ar_ready;
  logic [31:0]       in_ar_addr;
  logic [7:0]        in_ar_len;
  logic [2:0]        in_ar_size;
  logic [1:0]        in_ar_burst;
  logic [6:0]        in_ar_id;
  logic              in_r_valid, in_r_ready, in_r_last;
  logic [63:0]       in_r_data;
  logic [1:0]        in_r_resp;
  logic [6:0]        in_r_id;
  logic [3:0]        in_r_user;
  logic              out_ar_valid, out_ar_ready;
  logic [31:0]       out_ar_addr;
  logic [2:0]        out_ar_prot, out_ar_size;
  logic [3:0]        out_ar_region, out_ar_cache, out_ar_qos, out_ar_user;
  logic [7:0]        out_ar_len;
  logic [1:0]        out_ar_burst;
  logic              out_ar_lock;
  logic [6:0]        out_ar_id;
  logic              out_r_valid, out_r_ready, out_r_last;
  logic [63:0]       out_r_data;
  logic [1:0]        out_r_resp;
  logic [6:0]        out_r_id;
  logic [3:0]        out_r_user;
  logic [15:0]       err_cnt;
  logic [31:0]       err_addr;
  logic              err_irq, err_clr;

  int n_checks = 0;
  int n_err    = 0;
  int exp_err_cnt = 0;

  always #5 clk = ~clk;

  axi_filter_rd_perm dut (
    .i_clk(clk), .i_rst(rst), .START_ADDR(start_addr), .STOP_ADDR(stop_addr), .i_range_rd_en(range_en),
    .axi_in_ar_valid(in_ar_valid), .axi_in_ar_ready(in_ar_ready), .axi_in_ar_addr(in_ar_addr),
    .axi_in_ar_prot(3'b010), .axi_in_ar_region(4'h3), .axi_in_ar_len(in_ar_len), .axi_in_ar_size(in_ar_size),
    .axi_in_ar_burst(in_ar_burst), .axi_in_ar_lock(1'b0), .axi_in_ar_cache(4'h2), .axi_in_ar_qos(4'h1),
    .axi_in_ar_id(in_ar_id), .axi_in_ar_user(4'h9),
    .axi_in_r_valid(in_r_valid), .axi_in_r_ready(in_r_ready), .axi_in_r_data(in_r_data), .axi_in_r_resp(in_r_resp),
    .axi_in_r_last(in_r_last), .axi_in_r_id(in_r_id), .axi_in_r_user(in_r_user),
    .axi_out_ar_valid(out_ar_valid), .axi_out_ar_ready(out_ar_ready), .axi_out_ar_addr(out_ar_addr),
    .axi_out_ar_prot(out_ar_prot), .axi_out_ar_region(out_ar_region), .axi_out_ar_len(out_ar_len),
    .axi_out_ar_size(out_ar_size), .axi_out_ar_burst(out_ar_burst), .axi_out_ar_lock(out_ar_lock),
    .axi_out_ar_cache(out_ar_cache), .axi_out_ar_qos(out_ar_qos), .axi_out_ar_id(out_ar_id), .axi_out_ar_user(out_ar_user),
    .axi_out_r_valid(out_r_valid), .axi_out_r_ready(out_r_ready), .axi_out_r_data(out_r_data), .axi_out_r_resp(out_r_resp),
    .axi_out_r_last(out_r_last), .axi_out_r_id(out_r_id), .axi_out_r_user(out_r_user),
    .o_err_cnt(err_cnt), .o_err_addr(err_addr), .o_err_irq(err_irq), .i_err_clr(err_clr)
  );

  typedef struct {
    logic [3:0]  en;
    logic [1:0]  burst;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        fwd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one AR and wait (bounded) for its handshake; returns at the negedge of cycle N+1.
  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [6:0] id);
    int t = 0;
    @(negedge clk);
    in_ar_addr = a; in_ar_len = l; in_ar_size = s; in_ar_burst = b; in_ar_id = id;
    in_ar_valid = 1'b1;
    while (!in_ar_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("ar_accept_ready", in_ar_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_ar_valid = 1'b0;
  endtask

  // One slave R beat, checked for unchanged pass-through.
  task automatic slave_beat(input logic [6:0] id, input logic [63:0] d, input logic last, input logic [1:0] resp);
    @(negedge clk);
    out_r_valid = 1'b1; out_r_id = id; out_r_data = d; out_r_last = last; out_r_resp = resp; out_r_user = 4'h5;
    #1;
    check("r_pass_valid", in_r_valid, 1);
    check("r_pass_data", in_r_data, d);
    check("r_pass_id", in_r_id, id);
    check("r_pass_last", in_r_last, last);
    check("r_pass_resp", in_r_resp, resp);
    check("r_pass_user", in_r_user, 4'h5);
    check("r_pass_ready", out_r_ready, 1);
    @(posedge clk);
    #1;
    out_r_valid = 1'b0; out_r_last = 1'b0;
  endtask

  // Called at negedge N+1 after a blocked AR handshake: checks DRAIN gap, error beats and reporting.
  task automatic expect_err(input logic [31:0] a, input logic [7:0] l, input logic [6:0] id);
    check("blk_no_fwd", out_ar_valid, 0);
    check("blk_drain_quiet", in_r_valid, 0);
    for (int b = 0; b <= int'(l); b++) begin
      @(negedge clk);
      check("err_valid", in_r_valid, 1);
      check("err_resp", in_r_resp, 2'b11);
      check("err_id", in_r_id, id);
      check("err_data", in_r_data, 0);
      check("err_last", in_r_last, (b == int'(l)));
    end
    exp_err_cnt++;
    @(negedge clk);
    check("err_irq_pulse", err_irq, 1);
    check("err_cnt", err_cnt, exp_err_cnt);
    check("err_addr", err_addr, a);
    check("err_idle_after", in_r_valid, 0);
    @(negedge clk);
    check("err_irq_one_cycle", err_irq, 0);
  endtask

  task automatic fwd_check(input logic [31:0] a, input logic [7:0] l, input logic [6:0] id);
    check("fwd_valid", out_ar_valid, 1);
    check("fwd_addr", out_ar_addr, a);
    check("fwd_len", out_ar_len, l);
    check("fwd_id", out_ar_id, id);
    check("fwd_sideband", {out_ar_prot, out_ar_region, out_ar_cache, out_ar_qos, out_ar_user}, {3'b010, 4'h3, 4'h2, 4'h1, 4'h9});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{4'b0001, 2'b01, 32'h0000_1F00, 8'd3, 3'd3, 1'b1}; // INCR inside range0
    vecs[1]  = '{4'b0001, 2'b01, 32'h0000_1FF8, 8'd1, 3'd3, 1'b0}; // INCR crosses 0x1FFF
    vecs[2]  = '{4'b0000, 2'b00, 32'h0000_1000, 8'd0, 3'd2, 1'b0}; // FIXED, range disabled
    vecs[3]  = '{4'b0001, 2'b10, 32'h0000_1FF8, 8'd3, 3'd3, 1'b1}; // WRAP window 1FE0-1FFF
    vecs[4]  = '{4'b0001, 2'b00, 32'h0000_1FFC, 8'd7, 3'd2, 1'b1}; // FIXED ignores len
    vecs[5]  = '{4'b0001, 2'b01, 32'h0000_0FFF, 8'd0, 3'd0, 1'b0}; // below START
    vecs[6]  = '{4'b0001, 2'b11, 32'h0000_1000, 8'd0, 3'd0, 1'b0}; // reserved burst
    vecs[7]  = '{4'b0100, 2'b01, 32'h0000_4800, 8'd0, 3'd0, 1'b0}; // START>STOP range
    vecs[8]  = '{4'b1000, 2'b01, 32'hFFFF_FFF0, 8'd1, 3'd3, 1'b1}; // ends exactly at top
    vecs[9]  = '{4'b1000, 2'b01, 32'hFFFF_FFF8, 8'd1, 3'd3, 1'b0}; // carry out
    vecs[10] = '{4'b0011, 2'b01, 32'h0000_80F0, 8'd3, 3'd2, 1'b1}; // range1 upper edge
    vecs[11] = '{4'b0001, 2'b01, 32'h0000_8000, 8'd0, 3'd0, 1'b0}; // range1 not readable

    start_addr[0] = 32'h0000_1000; stop_addr[0] = 32'h0000_1FFF;
    start_addr[1] = 32'h0000_8000; stop_addr[1] = 32'h0000_80FF;
    start_addr[2] = 32'h0000_5000; stop_addr[2] = 32'h0000_4000;
    start_addr[3] = 32'hFFFF_F000; stop_addr[3] = 32'hFFFF_FFFF;
    range_en = 4'b0001;
    rst = 1'b1; err_clr = 1'b0;
    in_ar_valid = 1'b0; in_ar_addr = '0; in_ar_len = '0; in_ar_size = '0; in_ar_burst = '0; in_ar_id = '0;
    in_r_ready = 1'b1; out_ar_ready = 1'b1;
    out_r_valid = 1'b0; out_r_data = '0; out_r_resp = '0; out_r_last = 1'b0; out_r_id = '0; out_r_user = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ar_ready", in_ar_ready, 0);
    check("rst_out_ar_valid", out_ar_valid, 0);
    check("rst_r_valid", in_r_valid, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_irq", err_irq, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ar_ready", in_ar_ready, 1);

    // range-check table
    for (int i = 0; i < 12; i++) begin
      range_en = vecs[i].en;
      send_ar(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, 7'(i + 1));
      if (vecs[i].fwd) begin
        fwd_check(vecs[i].addr, vecs[i].len, 7'(i + 1));
        for (int b = 0; b <= int'(vecs[i].len); b++)
          slave_beat(7'(i + 1), 64'hD00D_0000_0000_0000 + 64'(i * 256 + b), (b == int'(vecs[i].len)), 2'(b & 1));
      end else begin
        expect_err(vecs[i].addr, vecs[i].len, 7'(i + 1));
      end
    end

    // clear
    range_en = 4'b0001;
    @(negedge clk);
    check("cnt_before_clr", err_cnt, exp_err_cnt);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err_cnt = 0;
    check("clr_cnt", err_cnt, 0);
    check("clr_addr", err_addr, 0);

    // clear wins over a same-cycle increment
    send_ar(32'h0000_3000, 8'd0, 3'd0, 2'b01, 7'h2A);
    @(negedge clk);
    check("clrpri_beat", in_r_valid, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clrpri_irq", err_irq, 1);
    check("clrpri_cnt", err_cnt, 0);
    check("clrpri_addr", err_addr, 0);

    // ordering: error beats only after both forwarded bursts complete
    send_ar(32'h0000_1000, 8'd0, 3'd2, 2'b01, 7'h11);
    check("ord_fwd1", out_ar_id, 7'h11);
    send_ar(32'h0000_1100, 8'd0, 3'd2, 2'b01, 7'h12);
    check("ord_fwd2", out_ar_id, 7'h12);
    send_ar(32'h0000_3000, 8'd1, 3'd2, 2'b01, 7'h13);
    repeat (3) @(negedge clk);
    check("ord_held_back", in_r_valid, 0);
    slave_beat(7'h11, 64'h1111, 1'b1, 2'b00);
    @(negedge clk);
    check("ord_still_held", in_r_valid, 0);
    slave_beat(7'h12, 64'h2222, 1'b1, 2'b00);
    @(negedge clk);
    check("ord_drain_gap", in_r_valid, 0);
    @(negedge clk);
    check("ord_err_valid", in_r_valid, 1);
    check("ord_err_id", in_r_id, 7'h13);
    check("ord_err_first_last", in_r_last, 0);
    @(negedge clk);
    check("ord_err_last", in_r_last, 1);
    exp_err_cnt++;
    @(negedge clk);
    check("ord_irq", err_irq, 1);
    check("ord_cnt", err_cnt, exp_err_cnt);

    // outstanding limit
    for (int k = 0; k < 4; k++) begin
      send_ar(32'h0000_1200, 8'd0, 3'd2, 2'b01, 7'(8'h20 + k));
      check("lim_fwd", out_ar_valid, 1);
    end
    send_ar(32'h0000_1200, 8'd0, 3'd2, 2'b01, 7'h24);
    check("lim_stall", out_ar_valid, 0);
    @(negedge clk);
    check("lim_stall2", out_ar_valid, 0);
    check("lim_ar_ready_low", in_ar_ready, 0);
    slave_beat(7'h20, 64'h20, 1'b1, 2'b00);
    @(negedge clk);
    check("lim_release", out_ar_valid, 1);
    check("lim_release_id", out_ar_id, 7'h24);
    for (int k = 1; k < 5; k++) slave_beat(7'(8'h20 + k), 64'(k), 1'b1, 2'b00);

    // reset in the middle of held error beats
    send_ar(32'h0000_3000, 8'd2, 3'd0, 2'b01, 7'h30);
    @(negedge clk);
    in_r_ready = 1'b0;
    check("bp_beat", in_r_valid, 1);
    @(negedge clk);
    check("bp_held_valid", in_r_valid, 1);
    check("bp_held_last", in_r_last, 0);
    check("pre_rst_cnt", err_cnt, exp_err_cnt);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_r_valid", in_r_valid, 0);
    check("mid_rst_r_resp", in_r_resp, 0);
    check("mid_rst_ar_ready", in_ar_ready, 0);
    check("mid_rst_out_ar", out_ar_valid, 0);
    check("mid_rst_cnt", err_cnt, 0);
    check("mid_rst_addr", err_addr, 0);
    rst = 1'b0; in_r_ready = 1'b1;
    @(negedge clk);
    check("after_rst_ready", in_ar_ready, 1);
    send_ar(32'h0000_1800, 8'd1, 3'd3, 2'b01, 7'h31);
    fwd_check(32'h0000_1800, 8'd1, 7'h31);
    slave_beat(7'h31, 64'hA, 1'b0, 2'b00);
    slave_beat(7'h31, 64'hB, 1'b1, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
